// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - unsigned sequential shift-add multiplier
//
// Purpose:
//   Computes m = x * y for WIDTH-bit unsigned operands, one shift-add step
//   per clock, so a wide multiply costs a single 2*WIDTH-bit adder.
//   A request is accepted on a clock edge with start=1 while idle. The
//   result appears on m together with a one-cycle done pulse, WIDTH edges
//   after acceptance. A zero operand short-circuits to a one-edge result.
//
// Ports:
//   clk    in   1         rising-edge clock
//   rst_n  in   1         asynchronous reset, active-low
//   start  in   1         request; sampled only while idle (busy=0)
//   x      in   WIDTH     multiplicand, captured on the accepted start
//   y      in   WIDTH     multiplier, captured on the accepted start
//   busy   out  1         high while a multiply is in progress
//   done   out  1         one-cycle pulse: m holds a new product
//   m      out  2*WIDTH   product register, held until the next completion

module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] m
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  // Value of count on the WIDTH-th (final) step.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc_step;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic operands_zero;
  logic accept_run;
  logic accept_zero;
  logic last_step;

  // A zero operand never needs the iterative path.
  assign operands_zero = (x == '0) || (y == '0);

  // Accumulator value after the current step's conditional add. It is also
  // the final product on the last step, so that add is not lost.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !operands_zero) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: output / control decode
  //--------------------------------------------------------------------------
  always_comb begin
    busy        = 1'b0;
    accept_run  = 1'b0;
    accept_zero = 1'b0;
    last_step   = 1'b0;
    case (state)
      IDLE: begin
        accept_run  = start && !operands_zero;
        accept_zero = start && operands_zero;
      end
      RUN: begin
        busy      = 1'b1;
        last_step = (count == LAST);
      end
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath: operand capture and shift-add iteration
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (accept_run) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, x};
      mplier <= y;
      count  <= '0;
    end else if (busy) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Result register and completion pulse
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '0;
      done <= 1'b0;
    end else begin
      // done defaults low so it can never stretch past one cycle per result.
      done <= accept_zero || last_step;
      if (accept_zero) begin
        m <= '0;
      end else if (last_step) begin
        m <= acc_step;
      end
    end
  end

endmodule
